cacheline_adaptor: RTL and testbench

- Memory-side responder for the cache arbiter's single line port.
- Accepts 256-bit line read/write requests: address_i, read_i, write_i, line_i in; line_o, resp_o out.
- Converts each request into a 4-beat, 64-bit burst transaction on physical memory.
- Sits between the arbiter and the burst memory model / DRAM controller.

---
 rtl/cacheline_adaptor.sv | 134 +++++++++++++
 tb/tb_cacheline_adaptor.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: memory-side responder for the arbiter's line port.
// Turns one 256-bit line read/write request into a 4-beat, 64-bit burst
// on the physical memory interface, then pulses resp for one cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   line_i / line_o     write line in / assembled read line out (registered)
//   address_i           line request address (low 5 bits dropped)
//   read_i / write_i    level requests, held until resp_o
//   resp_o              one-cycle completion pulse
//   burst_i / burst_o   read beat from memory / write beat to memory
//   address_o           32-byte aligned burst address
//   read_o / write_o    burst read / write request
//   resp_i              memory beat strobe, one beat per high cycle
module cacheline_adaptor #(
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned BEATS  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BEAT_W*BEATS-1:0]  line_i,
  output logic [BEAT_W*BEATS-1:0]  line_o,
  input  logic [31:0]              address_i,
  input  logic                     read_i,
  input  logic                     write_i,
  output logic                     resp_o,
  input  logic [BEAT_W-1:0]        burst_i,
  output logic [BEAT_W-1:0]        burst_o,
  output logic [31:0]              address_o,
  output logic                     read_o,
  output logic                     write_o,
  input  logic                     resp_i
);

  localparam int unsigned LINE_W = BEAT_W * BEATS;
  localparam int unsigned CNT_W  = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  // Bursts are line aligned: drop the byte offset within a 32-byte line.
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFE0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [LINE_W-1:0] buffer;
  logic [31:0]       address_reg;

  // Single FSM; every output is a register updated alongside the state so
  // that it already carries the value required in the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      buffer      <= '0;
      address_reg <= '0;
      line_o      <= '0;
      burst_o     <= '0;
      address_o   <= '0;
      read_o      <= 1'b0;
      write_o     <= 1'b0;
      resp_o      <= 1'b0;
    end else begin
      resp_o <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          // Read wins if both requests are raised together.
          if (read_i) begin
            state       <= READ;
            address_reg <= address_i & ADDR_MASK;
            address_o   <= address_i & ADDR_MASK;
            read_o      <= 1'b1;
          end else if (write_i) begin
            state       <= WRITE;
            address_reg <= address_i & ADDR_MASK;
            address_o   <= address_i & ADDR_MASK;
            buffer      <= line_i;
            burst_o     <= line_i[BEAT_W-1:0];
            write_o     <= 1'b1;
          end
        end

        READ: begin
          if (resp_i) begin
            buffer[count*BEAT_W +: BEAT_W] <= burst_i;
            count <= count + CNT_W'(1);
            if (count == LAST_BEAT) begin
              state     <= DONE;
              read_o    <= 1'b0;
              address_o <= '0;
              resp_o    <= 1'b1;
              // Final beat lands in the top lane; publish the whole line now.
              line_o    <= {burst_i, buffer[LINE_W-BEAT_W-1:0]};
            end
          end
        end

        WRITE: begin
          if (resp_i) begin
            count <= count + CNT_W'(1);
            if (count == LAST_BEAT) begin
              state     <= DONE;
              write_o   <= 1'b0;
              address_o <= '0;
              burst_o   <= '0;
              resp_o    <= 1'b1;
            end else begin
              // Present the next lane so burst_o always tracks the beat count.
              burst_o <= buffer[(count + CNT_W'(1))*BEAT_W +: BEAT_W];
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // address_reg keeps the accepted burst address for the whole transaction.
  logic unused_address_reg;
  assign unused_address_reg = ^address_reg;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed scenarios followed by
// randomized transactions, checked against a transaction-level model.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  // Model: last line delivered by a completed read (0 after reset).
  logic [255:0] exp_line_o;

  cacheline_adaptor #(.BEAT_W(64), .BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input bit e_rd, input bit e_wr,
                            input bit e_resp, input bit chk_addr,
                            input logic [31:0] e_addr, input logic [63:0] e_burst);
    check({tag, ".read_o"},  256'(read_o),  256'(e_rd));
    check({tag, ".write_o"}, 256'(write_o), 256'(e_wr));
    check({tag, ".resp_o"},  256'(resp_o),  256'(e_resp));
    check({tag, ".burst_o"}, 256'(burst_o), 256'(e_burst));
    check({tag, ".line_o"},  line_o,        exp_line_o);
    if (chk_addr) check({tag, ".address_o"}, 256'(address_o), 256'(e_addr));
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  // One full transaction. Starts and ends just after a negedge with the DUT
  // in IDLE. pat gives resp_i per burst cycle (LSB first) unless rnd is set.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wline, input logic [255:0] rline,
                         input logic [15:0] pat, input bit rnd, input string tag);
    logic [31:0] aligned;
    int n;
    int cyc;
    bit go;
    bit is_read;
    is_read = rd;
    aligned = {addr[31:5], 5'b0};
    address_i = addr;
    read_i    = rd;
    write_i   = wr;
    line_i    = wline;
    resp_i    = 1'($urandom);
    burst_i   = {$urandom, $urandom};
    @(negedge clk);
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 64) begin
      check_outs($sformatf("%s.c%0d", tag, cyc), is_read, !is_read, 1'b0, 1'b1,
                 aligned, is_read ? 64'h0 : wline[n*64 +: 64]);
      address_i = $urandom;
      line_i    = rand_line();
      go        = rnd ? 1'($urandom) : pat[cyc % 16];
      resp_i    = go;
      burst_i   = is_read ? rline[n*64 +: 64] : {$urandom, $urandom};
      if (go) n++;
      cyc++;
      @(negedge clk);
    end
    check({tag, ".beats"}, 256'(n), 256'(4));
    if (is_read) exp_line_o = rline;
    check_outs({tag, ".done"}, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
    read_i  = 1'b0;
    write_i = 1'b0;
    resp_i  = 1'($urandom);
    burst_i = {$urandom, $urandom};
    @(negedge clk);
    check_outs({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 64'h0);
    resp_i = 1'b0;
  endtask

  initial begin
    logic [255:0] l2;
    logic [255:0] l4;
    logic [255:0] lr;
    bit rd;

    // Reset with a pending read and memory strobe active.
    exp_line_o = '0;
    rst = 1'b1; read_i = 1'b1; write_i = 1'b0; resp_i = 1'b1;
    address_i = 32'h0000_1234; line_i = '0; burst_i = 64'h5555_5555_5555_5555;
    repeat (2) begin
      @(negedge clk);
      check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 64'h0);
    end
    rst = 1'b0; read_i = 1'b0; resp_i = 1'b0;
    @(negedge clk);
    check_outs("post_reset", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 64'h0);

    // Read without gaps.
    l2 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    run_txn(1'b1, 1'b0, 32'h0000_1234, '0, l2, 16'hFFFF, 1'b0, "read_nogap");

    // Read with gaps 1,0,0,1,1,0,1.
    run_txn(1'b1, 1'b0, 32'hA5A5_5A5F, '0, rand_line(), 16'h0059, 1'b0, "read_gaps");

    // Write with stalls; line_o must keep the last read line.
    l4 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
          64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    run_txn(1'b0, 1'b1, 32'hFFFF_FFE8, l4, '0, 16'h00B5, 1'b0, "write");

    // Both requests: read wins, back-to-back with further requests.
    run_txn(1'b1, 1'b1, 32'h0000_0040, rand_line(), rand_line(), 16'hFFFF, 1'b0, "both");
    run_txn(1'b0, 1'b1, 32'h1234_5678, rand_line(), '0, 16'hFFFF, 1'b0, "b2b_w");
    run_txn(1'b1, 1'b0, 32'h8765_4321, '0, rand_line(), 16'hFFFF, 1'b0, "b2b_r");

    // Reset after two beats of a read abandons it.
    lr = rand_line();
    address_i = 32'h0000_2000; read_i = 1'b1; resp_i = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      check_outs($sformatf("abort.b%0d", b), 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2000, 64'h0);
      resp_i = 1'b1; burst_i = lr[b*64 +: 64];
      @(negedge clk);
    end
    check_outs("abort.b2", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2000, 64'h0);
    rst = 1'b1; burst_i = lr[127:64];
    exp_line_o = '0;
    @(negedge clk);
    check_outs("abort.rst", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 64'h0);
    rst = 1'b0; read_i = 1'b0; resp_i = 1'b0;
    @(negedge clk);
    check_outs("abort.idle", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 64'h0);
    run_txn(1'b1, 1'b0, 32'h0000_2000, '0, rand_line(), 16'hFFFF, 1'b0, "after_abort");

    // Randomized transactions with random gaps.
    for (int t = 0; t < 24; t++) begin
      rd = 1'($urandom);
      run_txn(rd, !rd || 1'($urandom), $urandom, rand_line(), rand_line(),
              16'h0, 1'b1, $sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
